// File: rtl/vga_pkg.sv
// Shared constants and owner encoding for the framebuffer arbiter.
// 640x480 timing origin, 160x120x3 framebuffer, 4x4 pixel replication.
package vga_pkg;

  localparam int H_START    = 144;
  localparam int V_START    = 35;
  localparam int H_MAX      = 799;
  localparam int H_DISPLAY  = 640;
  localparam int V_DISPLAY  = 480;

  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int SCALE_LOG2 = 2;
  localparam int ADDR_W     = 15;
  localparam int PIX_W      = 3;

  localparam int FB_SIZE    = FB_W * FB_H;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_HREAD,
    OWN_HREAD_OOR
  } owner_e;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Scan-out address generator: decides fetch cycles and the fetch address.
// Ports: clk, reset, i_hpos, i_vpos -> o_fetch_now, o_fetch_addr.
module vga_fb_addr_gen
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        i_hpos,
  input  logic [9:0]        i_vpos,
  output logic              o_fetch_now,
  output logic [ADDR_W-1:0] o_fetch_addr
);

  localparam logic [9:0] H_F0   = 10'(H_START - 2);
  localparam logic [9:0] H_SPAN = 10'((FB_W - 1) << SCALE_LOG2);
  localparam logic [9:0] V_SPAN = 10'(FB_H << SCALE_LOG2);
  localparam logic [9:0] V_ST   = 10'(V_START);
  localparam logic [9:0] H_END  = 10'(H_MAX);
  localparam logic [9:0] SMASK  = 10'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] A_FBW = ADDR_W'(FB_W);

  logic [9:0]        w_hrel;
  logic [9:0]        w_vrel;
  logic              w_vact;
  logic              w_hact;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] r_fetch_addr;

  // Offsets wrap below the window start, so one
  // unsigned compare covers both bounds.
  assign w_hrel = i_hpos - H_F0;
  assign w_vrel = i_vpos - V_ST;
  assign w_vact = (w_vrel < V_SPAN);
  assign w_hact = (w_hrel <= H_SPAN) &&
                  ((w_hrel & SMASK) == '0);

  assign o_fetch_now  = w_vact && w_hact;
  // First fetch of a line reads line_base directly;
  // the running register covers the rest.
  assign o_fetch_addr = (i_hpos == H_F0) ? r_line_base
                                         : r_fetch_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_line_base <= '0;
    end else if (i_vpos == '0) begin
      r_line_base <= '0;
    end else if ((i_hpos == H_END) && w_vact &&
                 ((w_vrel & SMASK) == SMASK)) begin
      r_line_base <= r_line_base + A_FBW;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_addr <= '0;
    end else if (o_fetch_now) begin
      r_fetch_addr <= o_fetch_addr + 1'b1;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch has priority, host fills gaps.
// Ports: sync inputs, rgb out, host req/ack/rdata/rvalid, RAM addr/we/wdata/rdata.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              display_on,
  output logic [PIX_W-1:0]  rgb,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [PIX_W-1:0]  host_wdata,
  output logic              host_ack,
  output logic [PIX_W-1:0]  host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  localparam logic [ADDR_W-1:0] A_SIZE = ADDR_W'(FB_SIZE);

  logic              w_fetch_now;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_oor;
  logic              w_disp_go;
  logic              w_host_go;
  owner_e            w_own;
  owner_e            r_own;
  logic [PIX_W-1:0]  r_pix;
  logic [PIX_W-1:0]  r_rdata;
  logic              r_rvalid;

  vga_fb_addr_gen u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .i_hpos       (hpos),
    .i_vpos       (vpos),
    .o_fetch_now  (w_fetch_now),
    .o_fetch_addr (w_fetch_addr)
  );

  assign w_oor     = (host_addr >= A_SIZE);
  assign w_disp_go = !reset && w_fetch_now;
  assign w_host_go = !reset && !w_fetch_now && host_req;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    host_ack  = 1'b0;
    w_own     = OWN_NONE;
    unique case (1'b1)
      w_disp_go: begin
        mem_addr = w_fetch_addr;
        w_own    = OWN_DISP;
      end
      w_host_go: begin
        mem_addr  = host_addr;
        mem_we    = host_we && !w_oor;
        mem_wdata = host_wdata;
        host_ack  = 1'b1;
        if (!host_we) begin
          w_own = w_oor ? OWN_HREAD_OOR : OWN_HREAD;
        end
      end
      default: ;
    endcase
  end

  // r_own names who owned the RAM last cycle, i.e.
  // who mem_rdata belongs to this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_own    <= OWN_NONE;
      r_pix    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_own    <= w_own;
      r_rvalid <= (r_own == OWN_HREAD) ||
                  (r_own == OWN_HREAD_OOR);
      if (r_own == OWN_DISP) begin
        r_pix <= mem_rdata;
      end
      if (r_own == OWN_HREAD) begin
        r_rdata <= mem_rdata;
      end else if (r_own == OWN_HREAD_OOR) begin
        r_rdata <= '0;
      end
    end
  end

  assign rgb         = (display_on && !reset) ? r_pix : '0;
  assign host_rdata  = reset ? '0 : r_rdata;
  assign host_rvalid = r_rvalid && !reset;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural sync-read RAM.
// Table vectors for arbitration plus sequences for latency and reset.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        display_on;
  logic [2:0]  rgb;
  logic        host_req;
  logic        host_we;
  logic [14:0] host_addr;
  logic [2:0]  host_wdata;
  logic        host_ack;
  logic [2:0]  host_rdata;
  logic        host_rvalid;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata;

  logic [2:0]  ram [0:32767];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .display_on  (display_on),
    .rgb         (rgb),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int          h;
    int          v;
    logic        req;
    logic        we;
    logic [14:0] addr;
    logic [2:0]  wd;
    logic        e_ack;
    logic        e_we;
    logic        chk_a;
    logic [14:0] e_addr;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic setp(input int h, input int v);
    hpos = 10'(h);
    vpos = 10'(v);
    display_on = (h >= 144) && (h < 784) &&
                 (v >= 35) && (v < 515);
  endtask

  task automatic adv();
    if (hpos == 10'd799) begin
      setp(0, (vpos == 10'd524) ? 0 : int'(vpos) + 1);
    end else begin
      setp(int'(hpos) + 1, int'(vpos));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host(input logic r, input logic w,
                      input int a, input int d);
    host_req   = r;
    host_we    = w;
    host_addr  = 15'(a);
    host_wdata = 3'(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n_ack;
    int n_fetch;
    int n_spur;
    for (int i = 0; i < 32768; i++)
      ram[i] = (i < 19200) ? 3'(i) : 3'd5;

    vecs[0]  = '{100, 10, 1, 1, 15'd5,     3'd7, 1, 1, 1, 15'd5};
    vecs[1]  = '{142, 35, 1, 1, 15'd9,     3'd2, 0, 0, 1, 15'd0};
    vecs[2]  = '{143, 35, 1, 0, 15'd9,     3'd0, 1, 0, 1, 15'd9};
    vecs[3]  = '{100, 10, 1, 1, 15'd19200, 3'd3, 1, 0, 1, 15'd19200};
    vecs[4]  = '{100, 10, 0, 1, 15'd4,     3'd1, 0, 0, 0, 15'd0};
    vecs[5]  = '{142, 34, 1, 1, 15'd7,     3'd7, 1, 1, 1, 15'd7};
    vecs[6]  = '{142, 515, 1, 0, 15'd11,   3'd0, 1, 0, 1, 15'd11};
    vecs[7]  = '{779, 35, 1, 0, 15'd12,    3'd0, 1, 0, 1, 15'd12};
    vecs[8]  = '{778, 35, 1, 1, 15'd13,    3'd1, 0, 0, 0, 15'd0};
    vecs[9]  = '{146, 514, 1, 1, 15'd14,   3'd1, 0, 0, 0, 15'd0};
    vecs[10] = '{141, 35, 1, 0, 15'd15,    3'd0, 1, 0, 1, 15'd15};

    // reset state
    reset = 1'b1;
    setp(0, 0);
    host(1, 1, 5, 7);
    step(); step();
    display_on = 1'b1;
    #1;
    chk("rst_ack", host_ack, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_rgb", rgb, 0);
    step();
    reset = 1'b0;
    host(0, 0, 0, 0);
    step();

    // arbitration table
    for (int i = 0; i < NV; i++) begin
      setp(vecs[i].h, vecs[i].v);
      host(vecs[i].req, vecs[i].we,
           vecs[i].addr, vecs[i].wd);
      #1;
      chk($sformatf("vec%0d_ack", i), host_ack, vecs[i].e_ack);
      chk($sformatf("vec%0d_we", i), mem_we, vecs[i].e_we);
      if (vecs[i].chk_a)
        chk($sformatf("vec%0d_addr", i), mem_addr,
            vecs[i].e_addr);
      if (vecs[i].e_we)
        chk($sformatf("vec%0d_wdata", i), mem_wdata,
            vecs[i].wd);
      step();
    end
    host(0, 0, 0, 0);
    step(); step();

    // out-of-range read and write after a normal read
    setp(100, 10);
    host(1, 0, 7, 0);
    #1;
    chk("oor_rd0_ack", host_ack, 1);
    step();
    host(1, 0, 19200, 0);
    #1;
    chk("oor_rd_ack", host_ack, 1);
    chk("oor_rd_we", mem_we, 0);
    step();
    host(1, 1, 19200, 5);
    #1;
    chk("oor_wr_ack", host_ack, 1);
    chk("oor_wr_we", mem_we, 0);
    chk("rd0_rvalid", host_rvalid, 1);
    chk("rd0_rdata", host_rdata, 7);
    step();
    host(0, 0, 0, 0);
    #1;
    chk("oor_rvalid", host_rvalid, 1);
    chk("oor_rdata", host_rdata, 0);
    step();
    #1;
    chk("oor_wr_no_rvalid", host_rvalid, 0);
    step();

    // free-running lines 34..40
    n_ack = 0;
    n_fetch = 0;
    setp(700, 34);
    while (vpos != 10'd41) begin
      host(0, 0, 0, 0);
      if (vpos == 10'd36 && (hpos == 10'd142 ||
                              hpos == 10'd143))
        host(1, 0, 3, 0);
      if (vpos == 10'd40) host(1, 1, 5, 7);
      #1;
      if (vpos == 10'd35) begin
        if (hpos == 10'd144) chk("px_144_35", rgb, 0);
        if (hpos == 10'd148) chk("px_148_35", rgb, 1);
        if (hpos == 10'd164) chk("px_164_35", rgb, 7);
        if (hpos == 10'd783) chk("px_783_35", rgb, 7);
        if (hpos == 10'd784) chk("px_blank_35", rgb, 0);
      end
      if (vpos == 10'd36) begin
        if (hpos == 10'd142) begin
          chk("hrd_wait_ack", host_ack, 0);
          chk("hrd_wait_addr", mem_addr, 0);
        end
        if (hpos == 10'd143) begin
          chk("hrd_ack", host_ack, 1);
          chk("hrd_addr", mem_addr, 3);
        end
        if (hpos == 10'd144) chk("hrd_rv_early", host_rvalid, 0);
        if (hpos == 10'd145) begin
          chk("hrd_rvalid", host_rvalid, 1);
          chk("hrd_rdata", host_rdata, 3);
          chk("hrd_px_145", rgb, 0);
        end
        if (hpos == 10'd148) chk("hrd_px_148", rgb, 1);
      end
      if (vpos == 10'd39) begin
        if (hpos == 10'd142) chk("lb_addr_39", mem_addr, 160);
        if (hpos == 10'd144) chk("px_144_39", rgb, 0);
        if (hpos == 10'd148) chk("px_148_39", rgb, 1);
      end
      if (vpos == 10'd40) begin
        if (host_ack) n_ack++;
        else n_fetch++;
      end
      step();
      adv();
    end
    chk("line_acks", n_ack, 640);
    chk("line_fetches", n_fetch, 160);

    // line base through the end of the frame
    host(0, 0, 0, 0);
    setp(0, 0);
    step();
    for (int i = 0; i < 119; i++) begin
      setp(799, 38 + 4 * i);
      step();
    end
    setp(142, 514);
    #1;
    chk("lb_last_line", mem_addr, 19040);
    step();
    setp(799, 514);
    step();
    setp(142, 35);
    #1;
    chk("lb_frame_end", mem_addr, 19200);
    step();
    setp(0, 0);
    step();
    setp(142, 35);
    #1;
    chk("lb_cleared", mem_addr, 0);
    step();

    // reset during an outstanding read, mid-line
    setp(799, 38);
    step();
    n_spur = 0;
    for (int h = 138; h <= 152; h++) begin
      setp(h, 35);
      reset = (h >= 141) && (h <= 143);
      host(0, 0, 0, 0);
      if (h == 140 || reset) host(1, 0, 6, 0);
      if (h == 146 || h == 147) host(1, 0, 100, 0);
      #1;
      if (h == 140) chk("mr_pre_ack", host_ack, 1);
      if (h == 142) begin
        chk("mr_ack", host_ack, 0);
        chk("mr_addr", mem_addr, 0);
        chk("mr_we", mem_we, 0);
      end
      if (h >= 141 && h <= 148 && host_rvalid) n_spur++;
      if (h == 146) begin
        chk("mr_fetch_ack", host_ack, 0);
        chk("mr_fetch_addr", mem_addr, 0);
      end
      if (h == 147) begin
        chk("mr_host_ack", host_ack, 1);
        chk("mr_host_addr", mem_addr, 100);
      end
      if (h == 149) begin
        chk("mr_rvalid", host_rvalid, 1);
        chk("mr_rdata", host_rdata, 4);
      end
      if (h == 150) chk("mr_fetch2_addr", mem_addr, 1);
      if (h == 152) chk("mr_px_152", rgb, 1);
      step();
    end
    reset = 1'b0;
    host(0, 0, 0, 0);
    chk("mr_no_spurious_rvalid", n_spur, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
